// File: rtl/switch_pkg.sv
// Shared definitions for the switch debounce bank.
//
// Contents:
//   NUM_SWITCHES_DEFAULT   - default channel count of the bank
//   DEBOUNCE_LIMIT_DEFAULT - default stable-cycle requirement (10 ms at CLK_HZ)
//   CLK_HZ                 - board clock frequency the default limit is derived from
//   switch_state_t         - per-channel debounce FSM state
//   cnt_width()            - width of the per-channel stability counter
package switch_pkg;

  localparam int CLK_HZ                 = 25_000_000;
  localparam int NUM_SWITCHES_DEFAULT   = 4;
  // 10 ms worth of clock cycles.
  localparam int DEBOUNCE_LIMIT_DEFAULT = CLK_HZ / 100;

  // STABLE : debounced output equals the synchronised input, counter idle.
  // PENDING: synchronised input differs from the output, counting stable cycles.
  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } switch_state_t;

  // The counter only has to reach limit-1, so clog2(limit) bits are enough.
  // Floor at 1 bit so a degenerate limit still elaborates to a legal width.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/switch_debounce_bank_if.sv
// Bus between the raw switch pins, the debounce bank and its consumers.
//
// Signals (all NUM_SWITCHES wide, one bit per channel):
//   i_Switch - raw, asynchronous, bouncing switch levels (driven by the pins)
//   o_Switch - debounced, registered level
//   o_Rise   - one-cycle pulse on the edge o_Switch goes 0 -> 1
//   o_Fall   - one-cycle pulse on the edge o_Switch goes 1 -> 0
//   pending  - debug view: channel FSM is in PENDING
//
// Handshake: none. These are plain level/pulse signals; o_Rise and o_Fall
// are strobes valid for exactly the one cycle they are high, with no ready
// or back-pressure, so a consumer must sample them every cycle.
//
// Modports:
//   master - the debounce bank (consumes i_Switch, produces everything else)
//   slave  - pin side / consumers (drives i_Switch, observes outputs)
interface switch_debounce_bank_if
  import switch_pkg::*;
#(
  parameter int NUM_SWITCHES = NUM_SWITCHES_DEFAULT
);

  logic [NUM_SWITCHES-1:0] i_Switch;
  logic [NUM_SWITCHES-1:0] o_Switch;
  logic [NUM_SWITCHES-1:0] o_Rise;
  logic [NUM_SWITCHES-1:0] o_Fall;
  logic [NUM_SWITCHES-1:0] pending;

  modport master (
    input  i_Switch,
    output o_Switch,
    output o_Rise,
    output o_Fall,
    output pending
  );

  modport slave (
    output i_Switch,
    input  o_Switch,
    input  o_Rise,
    input  o_Fall,
    input  pending
  );

endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchroniser, stability counter,
// two-state FSM and registered rise/fall pulses.
//
// Ports:
//   i_Clk    - system clock, rising edge
//   i_Rst_L  - asynchronous active-low reset (release is synchronised upstream)
//   i_Switch - raw asynchronous switch level
//   o_Switch - debounced level, registered
//   o_Rise   - one-cycle pulse when o_Switch goes 0 -> 1
//   o_Fall   - one-cycle pulse when o_Switch goes 1 -> 0
//   o_State  - current FSM state, for observation only
//
// Latency: if edge k is the first edge sync1 samples a new level, o_Switch
// and the pulse update at edge k+1+DEBOUNCE_LIMIT. A level must be seen at
// sync2 on DEBOUNCE_LIMIT consecutive edges to be accepted.
// DEBOUNCE_LIMIT must be at least 2.
module debounce_channel
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_Switch,
  output logic          o_Switch,
  output logic          o_Rise,
  output logic          o_Fall,
  output switch_state_t o_State
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  // Synchroniser. Only sync2 is allowed to feed the debounce logic.
  logic sync1;
  logic sync2;

  // Registered state.
  switch_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic             sw_q;
  logic             rise_q;
  logic             fall_q;

  // Next-state values.
  switch_state_t    state_n;
  logic [CNT_W-1:0] cnt_n;
  logic             sw_n;
  logic             rise_n;
  logic             fall_n;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= i_Switch;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state  <= STABLE;
      cnt    <= CNT_ZERO;
      sw_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sw_q   <= sw_n;
      rise_q <= rise_n;
      fall_q <= fall_n;
    end
  end

  // The count is "edges on which sync2 has differed from the output".
  // Entering PENDING already accounts for one such edge, hence the start
  // value of 1; acceptance happens on the edge that would make it LIMIT.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sw_n    = sw_q;
    rise_n  = 1'b0;
    fall_n  = 1'b0;

    unique case (state)
      STABLE: begin
        cnt_n = CNT_ZERO;
        if (sync2 != sw_q) begin
          state_n = PENDING;
          cnt_n   = CNT_ONE;
        end
      end

      PENDING: begin
        if (sync2 == sw_q) begin
          // Bounced back before the limit: forget the partial count.
          state_n = STABLE;
          cnt_n   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_n = STABLE;
          cnt_n   = CNT_ZERO;
          sw_n    = sync2;
          rise_n  = sync2;
          fall_n  = ~sync2;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      default: begin
        state_n = STABLE;
        cnt_n   = CNT_ZERO;
      end
    endcase
  end

  assign o_Switch = sw_q;
  assign o_Rise   = rise_q;
  assign o_Fall   = fall_q;
  assign o_State  = state;

endmodule

// File: rtl/switch_debounce_bank.sv
// Debounce bank for the board switches. Sits between the raw switch pins
// and every switch consumer; each channel is fully independent.
//
// Ports:
//   i_Clk   - system clock, rising edge
//   i_Rst_L - asynchronous active-low reset (release synchronised upstream)
//   bus     - switch_debounce_bank_if.master:
//               i_Switch in; o_Switch, o_Rise, o_Fall, pending out
//
// Parameters:
//   NUM_SWITCHES   - channel count; must match the connected interface width
//   DEBOUNCE_LIMIT - consecutive stable cycles before the output follows (>= 2)
module switch_debounce_bank
  import switch_pkg::*;
#(
  parameter int NUM_SWITCHES   = NUM_SWITCHES_DEFAULT,
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_L,
  switch_debounce_bank_if.master        bus
);

  logic [NUM_SWITCHES-1:0] sw_w;
  logic [NUM_SWITCHES-1:0] rise_w;
  logic [NUM_SWITCHES-1:0] fall_w;
  logic [NUM_SWITCHES-1:0] pending_w;

  for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_chan
    switch_state_t state_w;

    debounce_channel #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
    ) u_chan (
      .i_Clk    (i_Clk),
      .i_Rst_L  (i_Rst_L),
      .i_Switch (bus.i_Switch[g]),
      .o_Switch (sw_w[g]),
      .o_Rise   (rise_w[g]),
      .o_Fall   (fall_w[g]),
      .o_State  (state_w)
    );

    assign pending_w[g] = (state_w == PENDING);
  end

  assign bus.o_Switch = sw_w;
  assign bus.o_Rise   = rise_w;
  assign bus.o_Fall   = fall_w;
  assign bus.pending  = pending_w;

endmodule

// File: tb/tb_switch_debounce_bank.sv
module tb_switch_debounce_bank;

  localparam int N = 4;
  localparam int L = 8;

  logic i_Clk = 1'b0;
  logic i_Rst_L;

  switch_debounce_bank_if #(.NUM_SWITCHES(N)) bus ();

  switch_debounce_bank #(
    .NUM_SWITCHES   (N),
    .DEBOUNCE_LIMIT (L)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 i_Clk = ~i_Clk;

  // ---------------- reference model ----------------
  // A level is accepted when the raw input, delayed two edges by the
  // synchroniser, has held a value different from the current output for
  // the last L edges. raw_q holds the raw sample of the last L+2 edges,
  // oldest first: entries 0..L-1 are exactly that delayed window.
  logic [N-1:0] raw_q[$];
  logic [N-1:0] m_sw;
  logic [N-1:0] m_rise;
  logic [N-1:0] m_fall;

  always @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      raw_q = {};
      for (int i = 0; i < L + 2; i++) raw_q.push_back('0);
      m_sw   = '0;
      m_rise = '0;
      m_fall = '0;
    end else begin
      raw_q.push_back(bus.i_Switch);
      void'(raw_q.pop_front());
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < N; c++) begin
        bit accept;
        accept = 1'b1;
        for (int j = 0; j < L; j++) begin
          if (raw_q[j][c] == m_sw[c]) accept = 1'b0;
        end
        if (accept) begin
          m_sw[c] = ~m_sw[c];
          if (m_sw[c]) m_rise[c] = 1'b1;
          else         m_fall[c] = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int rise_cnt[N];
  int fall_cnt[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clr_cnt();
    for (int c = 0; c < N; c++) begin
      rise_cnt[c] = 0;
      fall_cnt[c] = 0;
    end
  endtask

  // One clock edge, then check every output against the model mid-cycle.
  task automatic tick();
    @(posedge i_Clk);
    @(negedge i_Clk);
    chk("o_Switch vs model", 32'(bus.o_Switch), 32'(m_sw));
    chk("o_Rise vs model",   32'(bus.o_Rise),   32'(m_rise));
    chk("o_Fall vs model",   32'(bus.o_Fall),   32'(m_fall));
    chk("rise&fall overlap", 32'(bus.o_Rise & bus.o_Fall), 32'd0);
    for (int c = 0; c < N; c++) begin
      rise_cnt[c] += int'(bus.o_Rise[c]);
      fall_cnt[c] += int'(bus.o_Fall[c]);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  int hold[N];

  initial begin
    i_Rst_L      = 1'b0;
    bus.i_Switch = 4'hF;
    clr_cnt();

    // 1. reset values, then release with all switches held high
    ticks(3);
    chk("reset o_Switch", 32'(bus.o_Switch), 32'd0);
    chk("reset o_Rise",   32'(bus.o_Rise),   32'd0);
    chk("reset o_Fall",   32'(bus.o_Fall),   32'd0);
    chk("reset pending",  32'(bus.pending),  32'd0);
    i_Rst_L = 1'b1;
    ticks(9);
    chk("s1 before latency", 32'(bus.o_Switch), 32'h0);
    tick();
    chk("s1 o_Switch edge10", 32'(bus.o_Switch), 32'hF);
    chk("s1 o_Rise edge10",   32'(bus.o_Rise),   32'hF);
    tick();
    chk("s1 o_Rise one cycle", 32'(bus.o_Rise), 32'h0);

    // return all to 0
    bus.i_Switch = 4'h0;
    ticks(12);
    chk("s1 settle low", 32'(bus.o_Switch), 32'h0);

    // 2. clean press on channel 0
    clr_cnt();
    bus.i_Switch = 4'h1;
    ticks(9);
    chk("s2 before latency", 32'(bus.o_Switch), 32'h0);
    tick();
    chk("s2 o_Switch edge10", 32'(bus.o_Switch), 32'h1);
    chk("s2 o_Rise edge10",   32'(bus.o_Rise),   32'h1);
    ticks(5);
    chk("s2 rise count", 32'(rise_cnt[0]), 32'd1);
    chk("s2 fall count", 32'(fall_cnt[0]), 32'd0);

    // 3. bounce on channel 1: 7 high / 3 low for 100 cycles, then hold
    clr_cnt();
    for (int p = 0; p < 10; p++) begin
      bus.i_Switch = 4'h3;
      ticks(7);
      bus.i_Switch = 4'h1;
      ticks(3);
    end
    chk("s3 no change while bouncing", 32'(bus.o_Switch), 32'h1);
    chk("s3 no pulse while bouncing",  32'(rise_cnt[1] + fall_cnt[1]), 32'd0);
    bus.i_Switch = 4'h3;
    ticks(9);
    chk("s3 before latency", 32'(bus.o_Switch), 32'h1);
    tick();
    chk("s3 o_Switch edge10", 32'(bus.o_Switch), 32'h3);
    ticks(3);
    chk("s3 rise count", 32'(rise_cnt[1]), 32'd1);

    // 4. simultaneous channels
    bus.i_Switch = 4'h0;
    ticks(12);
    bus.i_Switch = 4'h5;
    ticks(9);
    chk("s4 before latency", 32'(bus.o_Switch), 32'h0);
    tick();
    chk("s4 o_Switch", 32'(bus.o_Switch), 32'h5);
    chk("s4 o_Rise",   32'(bus.o_Rise),   32'h5);
    bus.i_Switch = 4'h0;
    ticks(10);
    chk("s4 o_Fall", 32'(bus.o_Fall), 32'h5);
    tick();
    chk("s4 o_Fall one cycle", 32'(bus.o_Fall), 32'h0);

    // 5. reset while channel 2 is mid-PENDING (count 5)
    ticks(3);
    clr_cnt();
    bus.i_Switch = 4'h4;
    ticks(7);
    chk("s5 pending before reset", 32'(bus.pending), 32'h4);
    i_Rst_L = 1'b0;
    #1;
    chk("s5 outputs in reset", 32'({bus.o_Switch, bus.o_Rise, bus.o_Fall}), 32'h0);
    ticks(2);
    i_Rst_L = 1'b1;
    ticks(9);
    chk("s5 full latency restart", 32'(bus.o_Switch), 32'h0);
    tick();
    chk("s5 o_Switch edge10", 32'(bus.o_Switch), 32'h4);
    ticks(3);
    chk("s5 rise count", 32'(rise_cnt[2]), 32'd1);

    // 6. glitch boundary on channel 3
    clr_cnt();
    bus.i_Switch = 4'hC;
    ticks(7);
    bus.i_Switch = 4'h4;
    ticks(12);
    chk("s6 7-cycle glitch rejected", 32'(rise_cnt[3] + fall_cnt[3]), 32'd0);
    bus.i_Switch = 4'hC;
    ticks(8);
    bus.i_Switch = 4'h4;
    tick();
    chk("s6 8-cycle before latency", 32'(bus.o_Switch), 32'h4);
    tick();
    chk("s6 8-cycle accepted", 32'(bus.o_Switch), 32'hC);
    ticks(12);
    chk("s6 back low", 32'(bus.o_Switch), 32'h4);
    chk("s6 rise count", 32'(rise_cnt[3]), 32'd1);
    chk("s6 fall count", 32'(fall_cnt[3]), 32'd1);

    // random phase: independent random hold lengths per channel
    for (int c = 0; c < N; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic [N-1:0] nxt;
      nxt = bus.i_Switch;
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          nxt[c]  = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 14);
        end else begin
          hold[c]--;
        end
      end
      bus.i_Switch = nxt;
      if (cyc == 400) i_Rst_L = 1'b0;
      if (cyc == 402) i_Rst_L = 1'b1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
